sc_lane_scheduler: RTL and testbench

- Schedules lane scrolling and shares the single game-matrix write port between lane shifts and frog moves.
- Generates level-dependent lane ticks and queues one pending shift per lane.
- Grants the port to the frog-move requester or to one lane at a time, with alternation so lanes never starve.
- Sits between the game state machine (enable, level) and the matrix register bank.

---
 rtl/sc_game_pkg.sv | 26 ++
 rtl/sc_lane_scheduler_if.sv | 36 +++
 rtl/sc_rr_picker.sv | 36 +++
 rtl/sc_lane_scheduler.sv | 145 ++++++++++++++
 tb/tb_sc_lane_scheduler.sv | 217 +++++++++++++++++++++
 5 files changed

// File: rtl/sc_game_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | sc_game_pkg: shared constants, FSM encodings and level period helper |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package sc_game_pkg;

    localparam int         c_NUM_LANES   = 4;
    localparam int         c_CNT_WIDTH   = 20;
    localparam int         c_BASE_PERIOD = 1000000;
    localparam int         c_PERIOD_STEP = 200000;
    localparam logic [3:0] c_FAST_MASK   = 4'b0101;

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_ARB  = 2'd1;
    localparam logic [1:0] c_ST_FROG = 2'd2;
    localparam logic [1:0] c_ST_LANE = 2'd3;

    function automatic logic [31:0] calc_period(input logic [1:0]  level,
                                                input logic [31:0] base,
                                                input logic [31:0] step);
        return base - ({30'd0, level} * step);
    endfunction

endpackage
`default_nettype wire

// File: rtl/sc_lane_scheduler_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | sc_lane_scheduler_if: game-FSM / frog / matrix-port handshake bundle |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
interface sc_lane_scheduler_if
    import sc_game_pkg::*;
#(
    parameter int NUM_LANES = c_NUM_LANES
);
    logic                 SC_LANESCHEDULER_Enable_InHigh;
    logic [1:0]           SC_LANESCHEDULER_Level_InBUS;
    logic                 SC_LANESCHEDULER_FrogReq_InLow;
    logic                 SC_LANESCHEDULER_FrogAck_OutLow;
    logic [NUM_LANES-1:0] SC_LANESCHEDULER_LaneShift_OutBUS;
    logic                 SC_LANESCHEDULER_Overrun_OutHigh;

    modport master (
        output SC_LANESCHEDULER_Enable_InHigh,
        output SC_LANESCHEDULER_Level_InBUS,
        output SC_LANESCHEDULER_FrogReq_InLow,
        input  SC_LANESCHEDULER_FrogAck_OutLow,
        input  SC_LANESCHEDULER_LaneShift_OutBUS,
        input  SC_LANESCHEDULER_Overrun_OutHigh
    );

    modport slave (
        input  SC_LANESCHEDULER_Enable_InHigh,
        input  SC_LANESCHEDULER_Level_InBUS,
        input  SC_LANESCHEDULER_FrogReq_InLow,
        output SC_LANESCHEDULER_FrogAck_OutLow,
        output SC_LANESCHEDULER_LaneShift_OutBUS,
        output SC_LANESCHEDULER_Overrun_OutHigh
    );
endinterface
`default_nettype wire

// File: rtl/sc_rr_picker.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | sc_rr_picker: first pending lane at or after rr pointer, wrapping    |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module sc_rr_picker
    import sc_game_pkg::*;
#(
    parameter int NUM_LANES = c_NUM_LANES,
    parameter int IDX_W     = 2
) (
    input  wire logic [NUM_LANES-1:0] i_pending,
    input  wire logic [IDX_W-1:0]     i_rr_ptr,
    output logic      [IDX_W-1:0]     o_sel,
    output logic                      o_any
);
    int w_idx;

    // Scan from the farthest offset down so the closest match wins.
    always_comb begin
        o_sel = '0;
        o_any = 1'b0;
        w_idx = 0;
        for (int k = NUM_LANES - 1; k >= 0; k--) begin
            w_idx = int'(i_rr_ptr) + k;
            if (w_idx >= NUM_LANES) begin
                w_idx = w_idx - NUM_LANES;
            end
            if (i_pending[IDX_W'(w_idx)]) begin
                o_sel = IDX_W'(w_idx);
                o_any = 1'b1;
            end
        end
    end
endmodule
`default_nettype wire

// File: rtl/sc_lane_scheduler.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | sc_lane_scheduler: lane tick generation and matrix write-port arbiter |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module sc_lane_scheduler
    import sc_game_pkg::*;
#(
    parameter int                   NUM_LANES   = c_NUM_LANES,
    parameter int                   CNT_WIDTH   = c_CNT_WIDTH,
    parameter int                   BASE_PERIOD = c_BASE_PERIOD,
    parameter int                   PERIOD_STEP = c_PERIOD_STEP,
    parameter logic [NUM_LANES-1:0] FAST_MASK   = NUM_LANES'(c_FAST_MASK)
) (
    input  wire logic          SC_LANESCHEDULER_CLOCK_50,
    input  wire logic          SC_LANESCHEDULER_RESET_InLow,
    sc_lane_scheduler_if.slave bus
);
    localparam int IDX_W = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;

    logic                 w_enable, w_frog_req, w_tick, w_tick_evt, w_any;
    logic [CNT_WIDTH-1:0] w_period, r_count;
    logic                 r_tick, r_tick_cnt, r_last_frog, r_overrun;
    logic [NUM_LANES-1:0] r_pending, w_tick_set, w_served;
    logic [IDX_W-1:0]     r_rr_ptr, r_sel, w_pick;
    logic [1:0]           r_state, w_state_nxt;

    assign w_enable   = bus.SC_LANESCHEDULER_Enable_InHigh;
    assign w_frog_req = ~bus.SC_LANESCHEDULER_FrogReq_InLow;
    assign w_period   = CNT_WIDTH'(calc_period(bus.SC_LANESCHEDULER_Level_InBUS,
                                               32'(BASE_PERIOD), 32'(PERIOD_STEP)));
    // >= so a level change that shortens the period below the count wraps at once.
    assign w_tick     = w_enable && (r_count >= (w_period - CNT_WIDTH'(1)));
    assign w_tick_evt = r_tick && w_enable;
    assign w_tick_set = w_tick_evt ? (FAST_MASK | {NUM_LANES{r_tick_cnt}}) : '0;
    assign w_served   = (r_state == c_ST_LANE) ? (NUM_LANES'(1) << r_sel) : '0;

    sc_rr_picker #(
        .NUM_LANES (NUM_LANES),
        .IDX_W     (IDX_W)
    ) u_picker (
        .i_pending (r_pending),
        .i_rr_ptr  (r_rr_ptr),
        .o_sel     (w_pick),
        .o_any     (w_any)
    );

    always_ff @(posedge SC_LANESCHEDULER_CLOCK_50 or negedge SC_LANESCHEDULER_RESET_InLow) begin
        if (!SC_LANESCHEDULER_RESET_InLow) begin
            r_count    <= '0;
            r_tick     <= 1'b0;
            r_tick_cnt <= 1'b0;
        end else begin
            r_tick <= w_tick;
            if (w_tick) begin
                r_count <= '0;
            end else if (w_enable) begin
                r_count <= r_count + CNT_WIDTH'(1);
            end
            if (w_tick_evt) begin
                r_tick_cnt <= ~r_tick_cnt;
            end
        end
    end

    // A lane strobed in the same cycle its tick lands is re-armed, not overrun.
    always_ff @(posedge SC_LANESCHEDULER_CLOCK_50 or negedge SC_LANESCHEDULER_RESET_InLow) begin
        if (!SC_LANESCHEDULER_RESET_InLow) begin
            r_pending <= '0;
            r_overrun <= 1'b0;
        end else begin
            if (!w_enable) begin
                r_pending <= '0;
            end else begin
                r_pending <= (r_pending & ~w_served) | w_tick_set;
            end
            if (|(w_tick_set & r_pending & ~w_served)) begin
                r_overrun <= 1'b1;
            end
        end
    end

    always_ff @(posedge SC_LANESCHEDULER_CLOCK_50 or negedge SC_LANESCHEDULER_RESET_InLow) begin
        if (!SC_LANESCHEDULER_RESET_InLow) begin
            r_sel       <= '0;
            r_rr_ptr    <= '0;
            r_last_frog <= 1'b0;
        end else begin
            if ((r_state == c_ST_ARB) && (w_state_nxt == c_ST_LANE)) begin
                r_sel <= w_pick;
            end
            if (r_state == c_ST_FROG) begin
                r_last_frog <= 1'b1;
            end
            if (r_state == c_ST_LANE) begin
                r_last_frog <= 1'b0;
                r_rr_ptr    <= (r_sel == IDX_W'(NUM_LANES - 1)) ? '0 : r_sel + IDX_W'(1);
            end
        end
    end

    always_ff @(posedge SC_LANESCHEDULER_CLOCK_50 or negedge SC_LANESCHEDULER_RESET_InLow) begin
        if (!SC_LANESCHEDULER_RESET_InLow) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // The frog only wins twice in a row when no lane is waiting.
    always_comb begin
        w_state_nxt = r_state;
        if (!w_enable) begin
            w_state_nxt = c_ST_IDLE;
        end else begin
            case (r_state)
                c_ST_IDLE: w_state_nxt = c_ST_ARB;
                c_ST_ARB: begin
                    if (w_frog_req && (!r_last_frog || !w_any)) begin
                        w_state_nxt = c_ST_FROG;
                    end else if (w_any) begin
                        w_state_nxt = c_ST_LANE;
                    end
                end
                c_ST_FROG: w_state_nxt = c_ST_ARB;
                c_ST_LANE: w_state_nxt = c_ST_ARB;
                default:   w_state_nxt = c_ST_IDLE;
            endcase
        end
    end

    always_comb begin
        bus.SC_LANESCHEDULER_FrogAck_OutLow   = 1'b1;
        bus.SC_LANESCHEDULER_LaneShift_OutBUS = '1;
        case (r_state)
            c_ST_FROG: bus.SC_LANESCHEDULER_FrogAck_OutLow   = 1'b0;
            c_ST_LANE: bus.SC_LANESCHEDULER_LaneShift_OutBUS = ~w_served;
            default: ;
        endcase
    end

    assign bus.SC_LANESCHEDULER_Overrun_OutHigh = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_sc_lane_scheduler.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_sc_lane_scheduler: directed vector table plus corner sequences     |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module tb_sc_lane_scheduler;

    typedef struct {
        int         scen;
        int         cyc;
        logic [3:0] shift;
        logic       ack;
        logic       ovr;
    } vec_t;

    logic clk;
    logic rst_n;
    int   n_pass;
    int   n_total;

    sc_lane_scheduler_if #(.NUM_LANES(4)) u_if ();

    sc_lane_scheduler #(
        .NUM_LANES   (4),
        .CNT_WIDTH   (20),
        .BASE_PERIOD (10),
        .PERIOD_STEP (2),
        .FAST_MASK   (4'b0101)
    ) dut (
        .SC_LANESCHEDULER_CLOCK_50    (clk),
        .SC_LANESCHEDULER_RESET_InLow (rst_n),
        .bus                          (u_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    logic [3:0] tr_shift [3][64];
    logic       tr_ack   [3][64];
    logic       tr_ovr   [3][64];
    vec_t       vecs[$];

    task automatic check(input string name, input int cyc,
                         input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s @cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
    endtask

    task automatic adv(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic sample(output logic [3:0] s, output logic a, output logic o);
        @(negedge clk);
        s = u_if.SC_LANESCHEDULER_LaneShift_OutBUS;
        a = u_if.SC_LANESCHEDULER_FrogAck_OutLow;
        o = u_if.SC_LANESCHEDULER_Overrun_OutHigh;
    endtask

    // Leaves the bench just after the edge that opens cycle 0 with Enable high.
    task automatic start_run(input logic [1:0] lvl);
        rst_n = 1'b0;
        u_if.SC_LANESCHEDULER_Enable_InHigh = 1'b0;
        u_if.SC_LANESCHEDULER_Level_InBUS   = lvl;
        u_if.SC_LANESCHEDULER_FrogReq_InLow = 1'b1;
        adv(3);
        rst_n = 1'b1;
        u_if.SC_LANESCHEDULER_Enable_InHigh = 1'b1;
    endtask

    task automatic capture(input int scen, input int ncyc, input int req_from);
        logic [3:0] s;
        logic       a, o;
        for (int k = 0; k < ncyc; k++) begin
            if (k > 0) adv(1);
            u_if.SC_LANESCHEDULER_FrogReq_InLow = (k >= req_from) ? 1'b0 : 1'b1;
            sample(s, a, o);
            tr_shift[scen][k] = s;
            tr_ack[scen][k]   = a;
            tr_ovr[scen][k]   = o;
        end
    endtask

    initial begin
        logic [3:0] s;
        logic       a, o;
        int         n_act;
        n_pass  = 0;
        n_total = 0;

        // Level 0, no frog: lanes 0,2 then full burst from rr_ptr=3, then 0,2.
        vecs.push_back('{0, 12, 4'b1110, 1'b1, 1'b0});
        vecs.push_back('{0, 13, 4'b1111, 1'b1, 1'b0});
        vecs.push_back('{0, 14, 4'b1011, 1'b1, 1'b0});
        vecs.push_back('{0, 22, 4'b0111, 1'b1, 1'b0});
        vecs.push_back('{0, 24, 4'b1110, 1'b1, 1'b0});
        vecs.push_back('{0, 26, 4'b1101, 1'b1, 1'b0});
        vecs.push_back('{0, 28, 4'b1011, 1'b1, 1'b0});
        vecs.push_back('{0, 32, 4'b1110, 1'b1, 1'b0});
        vecs.push_back('{0, 34, 4'b1011, 1'b1, 1'b0});
        vecs.push_back('{0, 35, 4'b1111, 1'b1, 1'b0});
        // Level 3 (period 4): third tick finds lane 2 still pending.
        vecs.push_back('{1,  6, 4'b1110, 1'b1, 1'b0});
        vecs.push_back('{1,  8, 4'b1011, 1'b1, 1'b0});
        vecs.push_back('{1, 10, 4'b0111, 1'b1, 1'b0});
        vecs.push_back('{1, 12, 4'b1110, 1'b1, 1'b0});
        vecs.push_back('{1, 13, 4'b1111, 1'b1, 1'b1});
        vecs.push_back('{1, 14, 4'b1101, 1'b1, 1'b1});
        // Level 0, frog held low from cycle 21: frog/lane alternation.
        vecs.push_back('{2, 21, 4'b1111, 1'b1, 1'b0});
        vecs.push_back('{2, 22, 4'b1111, 1'b0, 1'b0});
        vecs.push_back('{2, 24, 4'b0111, 1'b1, 1'b0});
        vecs.push_back('{2, 26, 4'b1111, 1'b0, 1'b0});
        vecs.push_back('{2, 28, 4'b1110, 1'b1, 1'b0});
        vecs.push_back('{2, 30, 4'b1111, 1'b0, 1'b0});
        vecs.push_back('{2, 32, 4'b1101, 1'b1, 1'b1});
        vecs.push_back('{2, 34, 4'b1111, 1'b0, 1'b1});
        vecs.push_back('{2, 36, 4'b1011, 1'b1, 1'b1});
        vecs.push_back('{2, 38, 4'b1111, 1'b0, 1'b1});
        vecs.push_back('{2, 40, 4'b1110, 1'b1, 1'b1});
        vecs.push_back('{2, 41, 4'b1111, 1'b1, 1'b1});

        rst_n = 1'b0;
        u_if.SC_LANESCHEDULER_Enable_InHigh = 1'b0;
        u_if.SC_LANESCHEDULER_Level_InBUS   = 2'd0;
        u_if.SC_LANESCHEDULER_FrogReq_InLow = 1'b1;
        sample(s, a, o);
        check("reset_shift", 0, s, 4'b1111);
        check("reset_ack", 0, a, 1'b1);
        check("reset_overrun", 0, o, 1'b0);

        start_run(2'd0); capture(0, 36, 1000);
        start_run(2'd3); capture(1, 41, 1000);
        start_run(2'd0); capture(2, 42, 21);

        foreach (vecs[i]) begin
            check($sformatf("vec%0d_shift", i), vecs[i].cyc, tr_shift[vecs[i].scen][vecs[i].cyc], vecs[i].shift);
            check($sformatf("vec%0d_ack", i),   vecs[i].cyc, tr_ack[vecs[i].scen][vecs[i].cyc],   vecs[i].ack);
            check($sformatf("vec%0d_ovr", i),   vecs[i].cyc, tr_ovr[vecs[i].scen][vecs[i].cyc],   vecs[i].ovr);
        end

        n_act = 0;
        for (int k = 0; k < 36; k++)
            if (tr_shift[0][k] != 4'hF || !tr_ack[0][k]) n_act++;
        check("lvl0_active_cycles", 35, n_act, 8);
        n_act = 0;
        for (int k = 21; k < 42; k++)
            if (tr_shift[2][k] != 4'hF || !tr_ack[2][k]) n_act++;
        check("frog_alt_active_cycles", 41, n_act, 10);
        check("overrun_sticky", 40, tr_ovr[1][40], 1'b1);

        // Frog request while ARB is idle: ack next cycle, re-ack two later.
        start_run(2'd0);
        adv(3);
        u_if.SC_LANESCHEDULER_FrogReq_InLow = 1'b0;
        sample(s, a, o); check("idle_frog_c3", 3, a, 1'b1);
        adv(1); sample(s, a, o); check("idle_frog_c4", 4, a, 1'b0);
        adv(1); sample(s, a, o); check("idle_frog_c5", 5, a, 1'b1);
        adv(1); sample(s, a, o); check("idle_frog_c6", 6, a, 1'b0);
        adv(1); u_if.SC_LANESCHEDULER_FrogReq_InLow = 1'b1;
        sample(s, a, o); check("idle_frog_c7", 7, a, 1'b1);
        adv(1); sample(s, a, o); check("idle_frog_c8", 8, a, 1'b1);

        // Enable drop with lanes 0,1,2 pending, then resume from count 3.
        start_run(2'd0);
        adv(22);
        sample(s, a, o); check("pause_pre_strobe", 22, s, 4'b0111);
        adv(1);
        u_if.SC_LANESCHEDULER_Enable_InHigh = 1'b0;
        n_act = 0;
        for (int k = 23; k <= 39; k++) begin
            if (k > 23) adv(1);
            if (k == 31) u_if.SC_LANESCHEDULER_Enable_InHigh = 1'b1;
            sample(s, a, o);
            if (s != 4'hF || !a) n_act++;
        end
        check("pause_quiet_cycles", 39, n_act, 0);
        adv(1); sample(s, a, o); check("resume_lane0", 40, s, 4'b1110);
        adv(2); sample(s, a, o); check("resume_lane2", 42, s, 4'b1011);
        adv(2); sample(s, a, o); check("resume_no_lane1", 44, s, 4'b1111);

        // Asynchronous reset in the middle of a lane strobe.
        start_run(2'd0);
        adv(12);
        sample(s, a, o); check("rst_mid_pre", 12, s, 4'b1110);
        #1 rst_n = 1'b0;
        #1;
        check("rst_mid_shift", 12, u_if.SC_LANESCHEDULER_LaneShift_OutBUS, 4'b1111);
        check("rst_mid_ack", 12, u_if.SC_LANESCHEDULER_FrogAck_OutLow, 1'b1);
        adv(1);
        rst_n = 1'b1;
        adv(12); sample(s, a, o); check("rst_after_lane0", 12, s, 4'b1110);
        adv(2);  sample(s, a, o); check("rst_after_lane2", 14, s, 4'b1011);
        n_act = 0;
        for (int k = 15; k <= 21; k++) begin
            adv(1);
            sample(s, a, o);
            if (s != 4'hF || !a) n_act++;
        end
        check("rst_after_fast_only", 21, n_act, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
